nap_countdown_timer: RTL and testbench

- Downstream consumer of the manual time-setting stage: captures the six BCD digits (HH:MM:SS) when that stage signals setting complete.
- Counts down once per second and raises the wake alarm at 00:00:00.
- Drives the display digit bus and the alarm/buzzer enable.
- Start/pause comes from a keypad-derived pulse; the alarm is cleared by an acknowledge pulse or an auto-timeout.

---
 rtl/nap_countdown_timer.sv | 195 +++++++++++++++++++
 tb/tb_nap_countdown_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nap_countdown_timer.sv
// Countdown timer fed by the manual time-setting stage: loads HH:MM:SS on a setting-complete
// edge, counts down once per second, and raises the wake alarm at 00:00:00.
module nap_countdown_timer #(
  parameter int CLK_DIV   = 1000000,
  parameter int ALARM_SEC = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       complete_setting,
  input  logic [3:0] hour_ten_in,
  input  logic [3:0] hour_one_in,
  input  logic [3:0] min_ten_in,
  input  logic [3:0] min_one_in,
  input  logic [3:0] sec_ten_in,
  input  logic [3:0] sec_one_in,
  input  logic       start_stop,
  input  logic       alarm_ack,
  output logic [3:0] hour_ten_out,
  output logic [3:0] hour_one_out,
  output logic [3:0] min_ten_out,
  output logic [3:0] min_one_out,
  output logic [3:0] sec_ten_out,
  output logic [3:0] sec_one_out,
  output logic       running,
  output logic       alarm,
  output logic       load_error,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOADED = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  logic [2:0]    r_state;
  logic          r_cs_prev;
  logic          r_load_req;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_alarm_cnt;

  logic [2:0]    w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [AW-1:0] w_alarm_cnt_nxt;
  logic [23:0]   w_digits;
  logic [23:0]   w_digits_nxt;
  logic [23:0]   w_in_digits;
  logic [23:0]   w_dec;
  logic          w_in_ok;
  logic          w_load_ok;
  logic          w_load_bad;
  logic          w_tick;

  // One BCD digit of the borrow chain: {borrow_out, new_digit}.
  function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic b,
                                           input logic [3:0] top);
    if (!b)            return {1'b0, d};
    else if (d == 4'd0) return {1'b1, top};
    else               return {1'b0, d - 4'd1};
  endfunction

  assign w_digits    = {hour_ten_out, hour_one_out, min_ten_out, min_one_out,
                        sec_ten_out, sec_one_out};
  assign w_in_digits = {hour_ten_in, hour_one_in, min_ten_in, min_one_in,
                        sec_ten_in, sec_one_in};

  assign w_in_ok = (hour_ten_in <= 4'd9) && (hour_one_in <= 4'd9) &&
                   (min_ten_in <= 4'd5) && (min_one_in <= 4'd9) &&
                   (sec_ten_in <= 4'd5) && (sec_one_in <= 4'd9) &&
                   (w_in_digits != 24'd0);
  assign w_load_ok  = r_load_req && w_in_ok;
  assign w_load_bad = r_load_req && !w_in_ok;
  assign w_tick     = (r_presc == PRESC_MAX);
  assign state_dbg  = r_state;

  always_comb begin
    logic [4:0] s1, s10, m1, m10, h1;
    s1    = dec_digit(sec_one_out,  1'b1,   4'd9);
    s10   = dec_digit(sec_ten_out,  s1[4],  4'd5);
    m1    = dec_digit(min_one_out,  s10[4], 4'd9);
    m10   = dec_digit(min_ten_out,  m1[4],  4'd5);
    h1    = dec_digit(hour_one_out, m10[4], 4'd9);
    w_dec = {(h1[4] ? hour_ten_out - 4'd1 : hour_ten_out),
             h1[3:0], m10[3:0], m1[3:0], s10[3:0], s1[3:0]};
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_alarm_cnt_nxt = r_alarm_cnt;
    w_digits_nxt    = w_digits;
    if (w_load_ok) begin
      // A valid load wins over start_stop and alarm_ack in the same cycle.
      w_state_nxt     = S_LOADED;
      w_digits_nxt    = w_in_digits;
      w_presc_nxt     = '0;
      w_alarm_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_presc_nxt     = '0;
          w_alarm_cnt_nxt = '0;
        end
        S_LOADED: begin
          if (start_stop) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            w_digits_nxt = w_dec;
            w_presc_nxt  = '0;
            if (w_dec == 24'd0) begin
              w_state_nxt     = S_ALARM;
              w_alarm_cnt_nxt = '0;
            end else if (start_stop) begin
              w_state_nxt = S_PAUSE;
            end
          end else if (start_stop) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        S_PAUSE: begin
          if (start_stop) w_state_nxt = S_RUN;
        end
        S_ALARM: begin
          w_digits_nxt = 24'd0;
          if (alarm_ack) begin
            w_state_nxt     = S_IDLE;
            w_presc_nxt     = '0;
            w_alarm_cnt_nxt = '0;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            if (r_alarm_cnt == ALARM_LAST) begin
              w_state_nxt     = S_IDLE;
              w_alarm_cnt_nxt = '0;
            end else begin
              w_alarm_cnt_nxt = r_alarm_cnt + AW'(1);
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_presc_nxt     = '0;
          w_alarm_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cs_prev    <= 1'b0;
      r_load_req   <= 1'b0;
      r_presc      <= '0;
      r_alarm_cnt  <= '0;
      hour_ten_out <= 4'd0;
      hour_one_out <= 4'd0;
      min_ten_out  <= 4'd0;
      min_one_out  <= 4'd0;
      sec_ten_out  <= 4'd0;
      sec_one_out  <= 4'd0;
      running      <= 1'b0;
      alarm        <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      r_cs_prev    <= complete_setting;
      r_load_req   <= complete_setting && !r_cs_prev;
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_alarm_cnt  <= w_alarm_cnt_nxt;
      hour_ten_out <= w_digits_nxt[23:20];
      hour_one_out <= w_digits_nxt[19:16];
      min_ten_out  <= w_digits_nxt[15:12];
      min_one_out  <= w_digits_nxt[11:8];
      sec_ten_out  <= w_digits_nxt[7:4];
      sec_one_out  <= w_digits_nxt[3:0];
      running      <= (w_state_nxt == S_RUN);
      alarm        <= (w_state_nxt == S_ALARM);
      load_error   <= w_load_bad;
    end
  end

endmodule

// File: tb/tb_nap_countdown_timer.sv
// Bench for nap_countdown_timer with a 4-cycle second and a 3-second alarm window.
module tb_nap_countdown_timer;

  localparam int CLK_DIV   = 4;
  localparam int ALARM_SEC = 3;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOADED = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        complete_setting = 1'b0;
  logic        start_stop = 1'b0;
  logic        alarm_ack = 1'b0;
  logic [23:0] set_d = 24'd0;
  logic [3:0]  hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out;
  logic        running, alarm, load_error;
  logic [2:0]  state_dbg;
  logic [23:0] obs_d;

  logic [23:0] exp_q[$];
  logic [23:0] last_d = 24'd0;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clock = ~clock;

  nap_countdown_timer #(.CLK_DIV(CLK_DIV), .ALARM_SEC(ALARM_SEC)) dut (
    .clock(clock), .reset(reset), .complete_setting(complete_setting),
    .hour_ten_in(set_d[23:20]), .hour_one_in(set_d[19:16]),
    .min_ten_in(set_d[15:12]), .min_one_in(set_d[11:8]),
    .sec_ten_in(set_d[7:4]), .sec_one_in(set_d[3:0]),
    .start_stop(start_stop), .alarm_ack(alarm_ack),
    .hour_ten_out(hour_ten_out), .hour_one_out(hour_one_out),
    .min_ten_out(min_ten_out), .min_one_out(min_one_out),
    .sec_ten_out(sec_ten_out), .sec_one_out(sec_one_out),
    .running(running), .alarm(alarm), .load_error(load_error), .state_dbg(state_dbg)
  );

  assign obs_d = {hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every change of the displayed time must match the next queued expectation.
  always @(negedge clock) begin
    if (obs_d !== last_d) begin
      if (exp_q.size() == 0) check("unexpected_digits", obs_d, last_d);
      else check("digits", obs_d, exp_q.pop_front());
      last_d = obs_d;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] d, input logic bad);
    set_d = d;
    if (!bad) exp_q.push_back(d);
    complete_setting = 1'b1;
    step(1);
    complete_setting = 1'b0;
    step(1);
    check(bad ? "load_error_pulse" : "load_error_quiet", load_error, bad);
    if (bad) begin
      step(1);
      check("load_error_one_cycle", load_error, 1'b0);
    end
  endtask

  task automatic wait_alarm(input logic lvl, input int budget, output int c);
    c = 0;
    while (alarm !== lvl && c < budget) begin
      step(1);
      c++;
    end
  endtask

  initial begin
    step(3);
    check("rst_digits", obs_d, 24'd0);
    check("rst_running", running, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_load_error", load_error, 1'b0);
    check("rst_state", state_dbg, S_IDLE);
    reset = 1'b0;
    step(1);

    // 00:00:05 down to alarm, then auto-timeout
    do_load(24'h000005, 1'b0);
    check("t1_state_loaded", state_dbg, S_LOADED);
    for (int s = 4; s >= 0; s--) exp_q.push_back(24'(s));
    pulse_start();
    check("t1_running", running, 1'b1);
    wait_alarm(1'b1, 40, cyc);
    check("t1_cycles_to_alarm", cyc, 5 * CLK_DIV);
    check("t1_running_in_alarm", running, 1'b0);
    check("t1_state_alarm", state_dbg, S_ALARM);
    wait_alarm(1'b0, 40, cyc);
    check("t1_alarm_timeout", cyc, ALARM_SEC * CLK_DIV);
    check("t1_state_idle", state_dbg, S_IDLE);

    // 01:00:00 borrows across every digit in one step
    do_load(24'h010000, 1'b0);
    exp_q.push_back(24'h005959);
    exp_q.push_back(24'h005958);
    pulse_start();
    step(CLK_DIV);
    check("t2_first_tick", obs_d, 24'h005959);
    step(CLK_DIV);
    check("t2_second_tick", obs_d, 24'h005958);
    pulse_start();
    check("t2_paused", state_dbg, S_PAUSE);

    // invalid minutes-tens digit: rejected while paused
    do_load(24'h006700, 1'b1);
    check("t3_digits_kept", obs_d, 24'h005958);
    check("t3_state_kept", state_dbg, S_PAUSE);

    // zero duration rejected from IDLE
    exp_q.push_back(24'd0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    do_load(24'h000000, 1'b1);
    check("t4_state_idle", state_dbg, S_IDLE);

    // pause keeps the prescaler phase
    do_load(24'h000009, 1'b0);
    exp_q.push_back(24'h000008);
    exp_q.push_back(24'h000007);
    exp_q.push_back(24'h000006);
    pulse_start();
    step(2 * CLK_DIV);
    check("t5_two_ticks", obs_d, 24'h000007);
    step(1);
    pulse_start();
    check("t5_paused", state_dbg, S_PAUSE);
    step(20);
    check("t5_hold_digits", obs_d, 24'h000007);
    check("t5_hold_state", state_dbg, S_PAUSE);
    pulse_start();
    check("t5_resumed", running, 1'b1);
    cyc = 0;
    while (obs_d[3:0] != 4'd6 && cyc < 20) begin
      step(1);
      cyc++;
    end
    check("t5_resume_phase", cyc, CLK_DIV - 1);

    // reload from RUN, run to alarm, acknowledge
    do_load(24'h000002, 1'b0);
    check("t6_running_cleared", running, 1'b0);
    check("t6_state_loaded", state_dbg, S_LOADED);
    exp_q.push_back(24'h000001);
    exp_q.push_back(24'h000000);
    pulse_start();
    wait_alarm(1'b1, 40, cyc);
    check("t6_cycles_to_alarm", cyc, 2 * CLK_DIV);
    pulse_start();
    check("t6_start_ignored", alarm, 1'b1);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    check("t6_ack_alarm", alarm, 1'b0);
    check("t6_ack_state", state_dbg, S_IDLE);

    // asynchronous reset mid-run
    do_load(24'h000009, 1'b0);
    pulse_start();
    step(2);
    exp_q.push_back(24'd0);
    #2 reset = 1'b1;
    #1;
    check("t7_digits_zero", obs_d, 24'd0);
    check("t7_running_zero", running, 1'b0);
    check("t7_state_idle", state_dbg, S_IDLE);
    @(posedge clock);
    #1 reset = 1'b0;
    pulse_start();
    check("t7_needs_load", state_dbg, S_IDLE);

    // complete_setting held high for 10 cycles gives a single load
    set_d = 24'h000003;
    exp_q.push_back(24'h000003);
    exp_q.push_back(24'h000002);
    exp_q.push_back(24'h000001);
    complete_setting = 1'b1;
    step(2);
    check("t8_loaded", state_dbg, S_LOADED);
    pulse_start();
    step(7);
    check("t8_single_load_state", state_dbg, S_RUN);
    check("t8_single_load_digits", obs_d, 24'h000002);
    complete_setting = 1'b0;
    // start_stop lands on a tick: decrement then pause
    pulse_start();
    check("t8_tick_pause_state", state_dbg, S_PAUSE);
    check("t8_tick_pause_digits", obs_d, 24'h000001);

    // load beats start_stop on the same edge
    set_d = 24'h000004;
    exp_q.push_back(24'h000004);
    complete_setting = 1'b1;
    step(1);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    complete_setting = 1'b0;
    check("t9_load_wins", state_dbg, S_LOADED);
    check("t9_not_running", running, 1'b0);
    step(2);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
